mac_stop_host_ctrl: RTL

Host-side initiator for mac_stop_top; drives the other end of its load / compute / readback protocol.
- Accepts matrices A (MxK) and B (KxN) as one row-major word stream (all of A, then all of B).
- Writes both matrices into the block, signals end of load, and waits for mac_done.
- Reads C (MxN) back row-major onto an output stream, then releases the block.
- Sits between a DMA/test source-sink and mac_stop_top.

---
 rtl/mac_stop_pkg.sv | 29 ++
 rtl/mac_stop_host_ctrl_if.sv | 49 ++++
 rtl/mac_stop_addr_cnt.sv | 42 ++++
 rtl/mac_stop_host_ctrl.sv | 96 +++++++++
 4 files changed

// File: rtl/mac_stop_pkg.sv
// Shared definitions for the mac_stop block and its host-side controller:
// default dimensions, element widths and the controller state encoding.
package mac_stop_pkg;

  localparam int M_DEF      = 8;
  localparam int K_DEF      = 6;
  localparam int N_DEF      = 4;
  localparam int DW_INIT_DEF = 32;
  localparam int DW_RES_DEF  = 2 * DW_INIT_DEF + $clog2(K_DEF);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_REQ,
    ST_LOAD_A,
    ST_LOAD_B,
    ST_SEND_DONE,
    ST_WAIT_MAC,
    ST_WAIT_RES,
    ST_READ_C,
    ST_DRAIN,
    ST_RELEASE
  } ctrl_state_e;

  // Address width for an index range of n entries; never narrower than one bit.
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mac_stop_host_ctrl_if.sv
// Bundle of job control, data streams and block-side load/readback signals
// seen by the host controller (master) and its environment (slave).
interface mac_stop_host_ctrl_if
  import mac_stop_pkg::*;
#(
  parameter int M = M_DEF,
  parameter int K = K_DEF,
  parameter int N = N_DEF,
  parameter int DATA_WIDTH_INIT_MATRIX   = DW_INIT_DEF,
  parameter int DATA_WIDTH_RESULT_MATRIX = DW_RES_DEF
);

  logic start, busy, job_done;
  logic in_val, in_rdy;
  logic [DATA_WIDTH_INIT_MATRIX-1:0] in_data;
  logic out_val, out_rdy;
  logic [DATA_WIDTH_RESULT_MATRIX-1:0] out_data;
  logic host2block_val, host2block_rdy;
  logic block2host_rdy, block2host_val;
  logic start_reading_result_matrix, mac_done;
  logic [DATA_WIDTH_INIT_MATRIX-1:0] ext_data_in_a, ext_data_in_b;
  logic [addr_w(M)-1:0] ext_row_addr_a, ext_row_addr_c;
  logic [addr_w(K)-1:0] ext_col_addr_a, ext_row_addr_b;
  logic [addr_w(N)-1:0] ext_col_addr_b, ext_col_addr_c;
  logic ext_matrix_a_we, ext_matrix_b_we, ext_matrix_c_re;
  logic [DATA_WIDTH_RESULT_MATRIX-1:0] ext_data_out_c;
  logic done_sending_data, done_reading_result_matrix;

  modport master (
    input  start, in_val, in_data, out_rdy, host2block_rdy, block2host_val,
           start_reading_result_matrix, mac_done, ext_data_out_c,
    output busy, job_done, in_rdy, out_val, out_data, host2block_val, block2host_rdy,
           ext_data_in_a, ext_data_in_b, ext_row_addr_a, ext_col_addr_a,
           ext_row_addr_b, ext_col_addr_b, ext_row_addr_c, ext_col_addr_c,
           ext_matrix_a_we, ext_matrix_b_we, ext_matrix_c_re,
           done_sending_data, done_reading_result_matrix
  );

  modport slave (
    output start, in_val, in_data, out_rdy, host2block_rdy, block2host_val,
           start_reading_result_matrix, mac_done, ext_data_out_c,
    input  busy, job_done, in_rdy, out_val, out_data, host2block_val, block2host_rdy,
           ext_data_in_a, ext_data_in_b, ext_row_addr_a, ext_col_addr_a,
           ext_row_addr_b, ext_col_addr_b, ext_row_addr_c, ext_col_addr_c,
           ext_matrix_a_we, ext_matrix_b_we, ext_matrix_c_re,
           done_sending_data, done_reading_result_matrix
  );

endinterface

// File: rtl/mac_stop_addr_cnt.sv
// Row-major (row, col) element address counter; wraps by compare so that
// non-power-of-two dimensions never rely on natural overflow.
module mac_stop_addr_cnt
  import mac_stop_pkg::*;
#(
  parameter int ROWS = M_DEF,
  parameter int COLS = K_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      inc,
  input  logic                      clr,
  output logic [addr_w(ROWS)-1:0]   row,
  output logic [addr_w(COLS)-1:0]   col,
  output logic                      last
);

  localparam int RW = addr_w(ROWS);
  localparam int CW = addr_w(COLS);
  localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);

  assign last = (row == ROW_MAX) && (col == COL_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row <= '0;
      col <= '0;
    end else if (clr) begin
      row <= '0;
      col <= '0;
    end else if (inc) begin
      if (col == COL_MAX) begin
        col <= '0;
        row <= (row == ROW_MAX) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mac_stop_host_ctrl.sv
// Host-side initiator for mac_stop_top: loads A then B, waits for the MAC,
// streams C out row-major with backpressure, then releases the block.
//   IDLE/REQ        wait for start / request block for loading
//   LOAD_A/LOAD_B   write streamed elements into A then B
//   SEND_DONE       one-cycle end-of-load pulse
//   WAIT_MAC/WAIT_RES  wait for compute, then for result permission
//   READ_C/DRAIN/RELEASE  stream C, flush last element, release block
module mac_stop_host_ctrl
  import mac_stop_pkg::*;
#(
  parameter int M = M_DEF,
  parameter int K = K_DEF,
  parameter int N = N_DEF,
  parameter int DATA_WIDTH_INIT_MATRIX   = DW_INIT_DEF,
  parameter int DATA_WIDTH_RESULT_MATRIX = DW_RES_DEF
) (
  input logic                  clk,
  input logic                  reset,
  mac_stop_host_ctrl_if.master bus
);

  ctrl_state_e state;
  logic a_inc, b_inc, c_inc, cnt_clr;
  logic a_last, b_last, c_last;
  logic capture;
  logic out_val_q;
  logic [DATA_WIDTH_RESULT_MATRIX-1:0] out_data_q;

  assign bus.in_rdy  = ((state == ST_LOAD_A) || (state == ST_LOAD_B)) && bus.host2block_rdy;
  assign a_inc       = (state == ST_LOAD_A) && bus.in_val && bus.in_rdy;
  assign b_inc       = (state == ST_LOAD_B) && bus.in_val && bus.in_rdy;
  // A new element may enter the output register only when it is empty or draining.
  assign capture     = (state == ST_READ_C) && (!out_val_q || bus.out_rdy);
  assign c_inc       = capture;
  assign cnt_clr     = (state == ST_IDLE);

  assign bus.ext_matrix_a_we = a_inc;
  assign bus.ext_matrix_b_we = b_inc;
  assign bus.ext_matrix_c_re = (state == ST_READ_C);
  assign bus.ext_data_in_a   = a_inc ? bus.in_data : '0;
  assign bus.ext_data_in_b   = b_inc ? bus.in_data : '0;

  assign bus.busy           = (state != ST_IDLE) && (state != ST_RELEASE);
  assign bus.host2block_val = (state == ST_REQ) || (state == ST_LOAD_A) || (state == ST_LOAD_B);
  assign bus.block2host_rdy = (state == ST_WAIT_RES) || (state == ST_READ_C) || (state == ST_DRAIN);
  assign bus.done_sending_data          = (state == ST_SEND_DONE);
  assign bus.done_reading_result_matrix = (state == ST_RELEASE);
  assign bus.job_done       = (state == ST_RELEASE);
  assign bus.out_val        = out_val_q;
  assign bus.out_data       = out_data_q;

  mac_stop_addr_cnt #(.ROWS(M), .COLS(K)) u_cnt_a (
    .clk(clk), .reset(reset), .inc(a_inc), .clr(cnt_clr),
    .row(bus.ext_row_addr_a), .col(bus.ext_col_addr_a), .last(a_last)
  );

  mac_stop_addr_cnt #(.ROWS(K), .COLS(N)) u_cnt_b (
    .clk(clk), .reset(reset), .inc(b_inc), .clr(cnt_clr),
    .row(bus.ext_row_addr_b), .col(bus.ext_col_addr_b), .last(b_last)
  );

  mac_stop_addr_cnt #(.ROWS(M), .COLS(N)) u_cnt_c (
    .clk(clk), .reset(reset), .inc(c_inc), .clr(cnt_clr),
    .row(bus.ext_row_addr_c), .col(bus.ext_col_addr_c), .last(c_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      out_val_q  <= 1'b0;
      out_data_q <= '0;
    end else begin
      if (capture) begin
        out_val_q  <= 1'b1;
        out_data_q <= bus.ext_data_out_c;
      end else if (out_val_q && bus.out_rdy) begin
        out_val_q  <= 1'b0;
      end

      case (state)
        ST_IDLE:      if (bus.start) state <= ST_REQ;
        ST_REQ:       if (bus.host2block_rdy) state <= ST_LOAD_A;
        ST_LOAD_A:    if (a_inc && a_last) state <= ST_LOAD_B;
        ST_LOAD_B:    if (b_inc && b_last) state <= ST_SEND_DONE;
        ST_SEND_DONE: state <= ST_WAIT_MAC;
        ST_WAIT_MAC:  if (bus.mac_done) state <= ST_WAIT_RES;
        ST_WAIT_RES:  if (bus.block2host_val && bus.start_reading_result_matrix) state <= ST_READ_C;
        ST_READ_C:    if (capture && c_last) state <= ST_DRAIN;
        ST_DRAIN:     if (out_val_q && bus.out_rdy) state <= ST_RELEASE;
        ST_RELEASE:   state <= ST_IDLE;
        default:      state <= ST_IDLE;
      endcase
    end
  end

endmodule
